// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the memory access unit (memwrite, ltype, FSM states)
package mem_pkg;
  localparam logic [1:0] MW_NONE  = 2'b00;
  localparam logic [1:0] MW_WORD  = 2'b01;
  localparam logic [1:0] MW_BYTE  = 2'b10;
  localparam logic [1:0] MW_DWORD = 2'b11;
  localparam logic [1:0] LT_WORD  = 2'b00;
  localparam logic [1:0] LT_BYTEU = 2'b01;
  localparam logic [1:0] LT_BYTES = 2'b10;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} mau_state_t;
endpackage

// File: rtl/load_align.sv
// load_align: builds the 64-bit load result from beat words lo/hi, byte offset off, ltype and dtype
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [1:0]  off,
  input  logic [1:0]  ltype,
  input  logic        dtype,
  output logic [63:0] result
);
  logic [7:0] b;
  assign b = lo[{off, 3'b000} +: 8];
  always_comb begin
    result = dtype ? {hi, lo} :
             ltype == LT_BYTEU ? {56'd0, b} :
             ltype == LT_BYTES ? {{56{b[7]}}, b} :
             {{32{lo[31]}}, lo};
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer onto a 32-bit req/ack memory; ports: clk, reset, acc_* request, rdata/acc_done/acc_err/busy, mem_* bus
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_valid,
  input  logic [1:0]        memwrite,
  input  logic [1:0]        ltype,
  input  logic              dtype,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata,
  output logic              acc_done,
  output logic              acc_err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);
  mau_state_t state_q, state_d;
  logic [1:0] mw_q, mw_d, lt_q, lt_d;
  logic dw_q, dw_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] lo_q, lo_d, hi_q, hi_d;
  logic [63:0] aligned;
  logic dw_in, byte_in, mis_in, load_ok;
  assign dw_in   = memwrite == MW_DWORD || (memwrite == MW_NONE && dtype);
  assign byte_in = memwrite == MW_BYTE ||
                   (memwrite == MW_NONE && !dtype && (ltype == LT_BYTEU || ltype == LT_BYTES));
  assign mis_in  = dw_in ? |addr[2:0] : !byte_in && |addr[1:0];
  assign load_ok = mw_q == MW_NONE && !err_q;
  load_align u_align (
    .lo(lo_q), .hi(hi_q), .off(addr_q[1:0]), .ltype(lt_q), .dtype(dw_q), .result(aligned)
  );
  always_comb begin
    state_d = state_q;
    mw_d    = mw_q;
    lt_d    = lt_q;
    dw_d    = dw_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    case (state_q)
      IDLE: if (acc_valid) begin
        mw_d    = memwrite;
        lt_d    = ltype;
        dw_d    = dw_in;
        err_d   = mis_in;
        addr_d  = addr;
        wdata_d = wdata;
        state_d = mis_in ? DONE : BEAT0;
      end
      BEAT0: if (mem_ack) begin
        lo_d    = mem_rdata;
        state_d = dw_q ? BEAT1 : DONE;
      end
      BEAT1: if (mem_ack) begin
        hi_d    = mem_rdata;
        state_d = DONE;
      end
      DONE: begin
        rdata_d = load_ok ? XLEN'(aligned) : rdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mw_q    <= MW_NONE;
      lt_q    <= LT_WORD;
      dw_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      mw_q    <= mw_d;
      lt_q    <= lt_d;
      dw_q    <= dw_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end
  // the load result is presented during DONE itself and held afterwards from rdata_q
  assign rdata     = (state_q == DONE && load_ok) ? XLEN'(aligned) : rdata_q;
  assign acc_done  = state_q == DONE;
  assign acc_err   = acc_done && err_q;
  assign busy      = state_q != IDLE;
  assign mem_req   = state_q == BEAT0 || state_q == BEAT1;
  assign mem_we    = mem_req && mw_q != MW_NONE;
  assign mem_be    = !mem_req ? 4'b0000 : mw_q == MW_BYTE ? 4'b0001 << addr_q[1:0] : 4'b1111;
  // doubleword addresses are 8-aligned, so the second beat just sets bit 2
  assign mem_addr  = {addr_q[ADDR_W-1:3], addr_q[2] | (state_q == BEAT1), 2'b00};
  assign mem_wdata = mw_q == MW_BYTE ? {4{wdata_q[7:0]}} :
                     state_q == BEAT1 ? wdata_q[63:32] : wdata_q[31:0];
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the multicycle main control FSM, between the datapath and the unified instruction/data memory.
- Executes the access selected by the control word: memwrite[1:0], ltype[1:0] and dtype. Loads and stores may be byte, word or doubleword.
- The external memory port is 32 bits wide with byte enables and a req/ack handshake, so a doubleword access is split into two beats.
- Returns a 64-bit extended load result and a one-cycle completion pulse; the datapath holds its state on busy.

Parameters:
ADDR_W, 32, byte-address width
XLEN, 64, datapath / load-result width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
acc_valid  in  1  access request; sampled only in IDLE
memwrite  in  2  00 load, 01 store word, 10 store byte, 11 store doubleword
ltype  in  2  load type: 00 word, 01 byte zero-extend, 10 byte sign-extend
dtype  in  1  1 = doubleword load (overrides ltype)
addr  in  ADDR_W  byte address
wdata  in  XLEN  store data
rdata  out  XLEN  extended load result; held until the next load completes
acc_done  out  1  one-cycle completion pulse
acc_err  out  1  misaligned-access flag; valid while acc_done is high
busy  out  1  high in every state except IDLE
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_be  out  4  memory byte enables
mem_addr  out  ADDR_W  memory word address (low 2 bits = 0)
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data
mem_ack  in  1  memory acknowledge

Behaviour:
- Reset (already decided): one clock, clk; reset is asynchronous and active-high.
  - All state returns to IDLE.
  - mem_req, mem_we, mem_be, acc_done, acc_err, busy and rdata are all 0.
  - Reset mid-access drops mem_req immediately; the partial access is abandoned with no done pulse.
- States are IDLE, BEAT0, BEAT1, DONE.
- IDLE, with acc_valid=1:
  - Register the request fields: memwrite, ltype, dtype, addr, wdata.
  - Compute misalignment: doubleword needs addr[2:0]=0, word needs addr[1:0]=0, byte is always aligned.
  - Misaligned -> DONE with acc_err=1 and no memory request issued.
  - Aligned -> BEAT0.
- BEAT0:
  - Drive mem_req=1 and mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - On mem_ack=1: go to BEAT1 if doubleword, else DONE.
  - Without ack, stay in BEAT0 with all mem_* outputs stable.
- BEAT1:
  - Drive mem_req=1 and mem_addr = BEAT0 address + 4.
  - On mem_ack=1 go to DONE; otherwise stay.
- DONE: acc_done=1 for one cycle, then IDLE. acc_valid is ignored in DONE.
- mem_req and mem_we are decoded from the state register only; there is no combinational path from acc_valid.
- Ack is allowed in the first request cycle (zero wait states).
- Latency with zero wait states: request accepted at edge k; acc_done is high in cycle k+2 for byte/word and k+3 for doubleword.
- Doubleword layout is little-endian: the low word is at addr and the high word at addr+4.
- Stores:
  - Word: mem_we=1, be=1111, mem_wdata = wdata[31:0].
  - Byte: be = 0001 << addr[1:0], mem_wdata = wdata[7:0] replicated into all 4 lanes.
  - Doubleword: beat0 sends wdata[31:0], beat1 sends wdata[63:32], be=1111 on both beats.
- Loads: mem_we=0, be=1111.
  - Capture mem_rdata on every ack (beat0 into the low word, beat1 into the high word).
  - rdata updates in the DONE cycle:
    - word: sign-extend to 64 bits
    - byte: select lane addr[1:0], zero- or sign-extend per ltype
    - doubleword: concatenate {beat1, beat0}
- Stores and erroring accesses leave rdata unchanged.
- ltype=11 is treated as a word load.
- acc_valid held high through DONE starts a new access in the following IDLE cycle; the requester drops acc_valid on acc_done.

Decomposition:
- Package mem_pkg holds:
  - memwrite encodings: MW_NONE, MW_WORD, MW_BYTE, MW_DWORD
  - ltype encodings: LT_WORD, LT_BYTEU, LT_BYTES
  - the mau_state_t enum {IDLE, BEAT0, BEAT1, DONE}
- One combinational sub-module, load_align: inputs are the beat words, addr[1:0], ltype and dtype; output is the 64-bit extended result.

Test Plan:
- Byte load with sign extension: LB at addr 0x0000_0013, memory word 0x80FF_7F01, zero wait -> rdata=0xFFFF_FFFF_FFFF_FF80; acc_done at k+2; exactly one mem_req cycle with be=1111.
- Byte load with zero extension: LBU at the same address and data -> rdata=0x0000_0000_0000_0080.
- Doubleword store, 2 wait states per beat: SD at 0x0000_0040, wdata=0x1122_3344_5566_7788 -> beat0 addr 0x40 data 0x5566_7788, beat1 addr 0x44 data 0x1122_3344; mem_* outputs stable across waits; acc_done at k+7.
- Byte store to lane 2: SB at 0x0000_0006, wdata[7:0]=0xAB -> be=0100, mem_wdata=0xABAB_ABAB, mem_we=1, rdata unchanged.
- Misaligned access: LW at 0x0000_0002, and separately LD at 0x0000_0004 -> no mem_req; acc_done and acc_err high at k+1 (the DONE cycle).
- Reset mid-beat: assert reset during BEAT1 of an LD -> mem_req low combinationally, no acc_done; rdata=0, busy=0; a fresh LW after reset release completes normally.
